// File: rtl/dist_alu_pkg.sv
// Shared opcode encoding and trace-entry sizing for the distributed ALU pipe.
package dist_alu_pkg;

    localparam int OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_MUL   = 4'd0,
        OP_DIV   = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_XNOR  = 4'd7,
        OP_NOT_A = 4'd8,
        OP_NOT_B = 4'd9,
        OP_NAND  = 4'd10,
        OP_NOR   = 4'd11
    } op_e;

    // Trace entry is {a, b, op, result} of one lane.
    function automatic int trc_entry_w(input int w);
        return w + w + OP_W + 2 * w;
    endfunction

endpackage

// File: rtl/dist_alu_pipe_alu_lane.sv
// One combinational ALU lane: W-bit operands, 2*W-bit result, flags when DIST_ALU_FLAGS_EN.
// Latency: 0 cycles. Backpressure: none, pure function of its inputs.
// Flags bit order: {zero, div_by_zero, illegal_op}.
module alu_lane
    import dist_alu_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [OP_W-1:0] op,
    output logic [2*W-1:0]  res
`ifdef DIST_ALU_FLAGS_EN
    ,
    output logic [2:0]      flags
`endif
);

    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;
    logic [W-1:0]   zu;

    always_comb begin
        zu  = '0;
        ax  = {zu, a};
        bx  = {zu, b};
        res = '0;
        case (op)
            OP_MUL:   res = ax * bx;
            OP_DIV:   res = (b == '0) ? '1 : ax / bx;
            OP_ADD:   res = ax + bx;
            OP_SUB:   res = ax - bx;
            OP_AND:   res = {zu, a & b};
            OP_OR:    res = {zu, a | b};
            OP_XOR:   res = {zu, a ^ b};
            OP_XNOR:  res = {zu, ~(a ^ b)};
            OP_NOT_A: res = {zu, ~a};
            OP_NOT_B: res = {zu, ~b};
            OP_NAND:  res = {zu, ~(a & b)};
            OP_NOR:   res = {zu, ~(a | b)};
            default:  res = '0;
        endcase
    end

`ifdef DIST_ALU_FLAGS_EN
    always_comb begin
        flags    = '0;
        flags[2] = (res == '0);
        flags[1] = (op == OP_DIV) && (b == '0);
        flags[0] = (op >= OP_W'(12));
    end
`endif

endmodule

// File: rtl/dist_alu_pipe.sv
// LANES parallel ALU lanes behind a 1-entry valid/ready output register, plus a DEPTH-entry trace of outputs.
// Latency: 1 cycle accept-to-out_valid. Backpressure: in_ready = !out_valid || out_ready (full throughput).
// Optional DIST_ALU_FLAGS_EN adds the per-lane flags output.
module dist_alu_pipe
    import dist_alu_pkg::*;
#(
    parameter int W     = 4,
    parameter int LANES = 4,
    parameter int DEPTH = 10,
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int TRC_W = trc_entry_w(W)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*W-1:0]       a,
    input  logic [LANES*W-1:0]       b,
    input  logic [LANES*OP_W-1:0]    op,
    input  logic [SEL_W-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           d,
    output logic [LANES*2*W-1:0]     lane_res,
    input  logic                     trc_clr,
    input  logic [IDX_W-1:0]         trc_idx,
    output logic [TRC_W-1:0]         trc_data,
    output logic [CNT_W-1:0]         trc_count,
    output logic                     trc_full
`ifdef DIST_ALU_FLAGS_EN
    ,
    output logic [LANES*3-1:0]       flags
`endif
);

    localparam int RW = 2 * W;
    localparam int PW = $clog2(4 * DEPTH) + 1;

    logic [LANES*RW-1:0] lane_next;
`ifdef DIST_ALU_FLAGS_EN
    logic [LANES*3-1:0]  flag_next;
`endif

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        alu_lane #(.W(W)) u_lane (
            .a   (a[g*W +: W]),
            .b   (b[g*W +: W]),
            .op  (op[g*OP_W +: OP_W]),
            .res (lane_next[g*RW +: RW])
`ifdef DIST_ALU_FLAGS_EN
            ,
            .flags (flag_next[g*3 +: 3])
`endif
        );
    end

    // Out-of-range selects (non-power-of-two LANES) fall back to lane 0.
    int sel_i;
    always_comb begin
        sel_i = 0;
        if (int'(sel) < LANES) sel_i = int'(sel);
    end

    logic            accept;
    logic            out_hs;
    logic [W-1:0]    cap_a;
    logic [W-1:0]    cap_b;
    logic [OP_W-1:0] cap_op;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            d         <= '0;
            lane_res  <= '0;
            cap_a     <= '0;
            cap_b     <= '0;
            cap_op    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            d         <= lane_next[sel_i*RW +: RW];
            lane_res  <= lane_next;
            cap_a     <= a[sel_i*W +: W];
            cap_b     <= b[sel_i*W +: W];
            cap_op    <= op[sel_i*OP_W +: OP_W];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DIST_ALU_FLAGS_EN
    always_ff @(posedge clk) begin
        if (reset)       flags <= '0;
        else if (accept) flags <= flag_next;
    end
`endif

    logic [TRC_W-1:0] trc_mem [DEPTH];
    logic [IDX_W-1:0] wr_ptr;
    logic             trc_we;

    // Clear beats a coincident output handshake: that entry is never logged.
    assign trc_we = out_hs && !trc_clr;

    always_ff @(posedge clk) begin
        if (reset || trc_clr) begin
            wr_ptr    <= '0;
            trc_count <= '0;
        end else if (trc_we) begin
            wr_ptr    <= (wr_ptr == IDX_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (trc_count != CNT_W'(DEPTH)) trc_count <= trc_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && trc_we) trc_mem[wr_ptr] <= {cap_a, cap_b, cap_op, d};
    end

    assign trc_full = (trc_count == CNT_W'(DEPTH));

    // Oldest entry sits trc_count slots behind the write pointer.
    logic [PW-1:0]    rd_sum;
    logic [IDX_W-1:0] rd_ptr;
    logic             rd_ok;

    always_comb begin
        rd_sum = PW'(wr_ptr) + PW'(DEPTH) - PW'(trc_count) + PW'(trc_idx);
        if (rd_sum >= PW'(DEPTH)) rd_sum = rd_sum - PW'(DEPTH);
        if (rd_sum >= PW'(DEPTH)) rd_sum = rd_sum - PW'(DEPTH);
        rd_ptr   = rd_sum[IDX_W-1:0];
        rd_ok    = (CNT_W'(trc_idx) < trc_count);
        trc_data = rd_ok ? trc_mem[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_dist_alu_pipe.sv
// Directed bench for dist_alu_pipe at W=4, LANES=4, DEPTH=10 with hand-computed expectations.
module tb_dist_alu_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] op;
    logic [1:0]  sel;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  d;
    logic [31:0] lane_res;
    logic        trc_clr;
    logic [3:0]  trc_idx;
    logic [19:0] trc_data;
    logic [3:0]  trc_count;
    logic        trc_full;
`ifdef DIST_ALU_FLAGS_EN
    logic [11:0] flags;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    dist_alu_pipe #(.W(4), .LANES(4), .DEPTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .lane_res  (lane_res),
        .trc_clr   (trc_clr),
        .trc_idx   (trc_idx),
        .trc_data  (trc_data),
        .trc_count (trc_count),
        .trc_full  (trc_full)
`ifdef DIST_ALU_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic set_lane(input int i, input logic [3:0] av, input logic [3:0] bv, input logic [3:0] opv);
        a[i*4 +: 4]  = av;
        b[i*4 +: 4]  = bv;
        op[i*4 +: 4] = opv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; trc_clr = 1'b0;
        trc_idx = '0; sel = '0; a = '0; b = '0; op = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_d", d, 0);
        check("rst_lane_res", lane_res, 0);
        check("rst_trc_count", trc_count, 0);
        check("rst_trc_full", trc_full, 0);
        check("rst_in_ready", in_ready, 1);

        // All-lane vector: MUL, DIV, SUB wrap, DIV by zero
        set_lane(0, 4'd7, 4'd6, 4'd0);
        set_lane(1, 4'd13, 4'd4, 4'd1);
        set_lane(2, 4'd3, 4'd5, 4'd3);
        set_lane(3, 4'd9, 4'd0, 4'd1);
        sel = 2'd0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("mul_out_valid", out_valid, 1);
        check("mul_d", d, 8'd42);
        check("lane0_mul", lane_res[7:0], 8'd42);
        check("lane1_div", lane_res[15:8], 8'd3);
        check("lane2_sub", lane_res[23:16], 8'hFE);
        check("lane3_div0", lane_res[31:24], 8'hFF);
        tick();
        check("one_cycle_valid", out_valid, 0);
        check("trc_count_1", trc_count, 1);
        trc_idx = 4'd0; #1;
        check("trc_e1", trc_data, 20'h7602A);

        // Backpressure: accept 9+8 on lane 2, then hold with a new set pending
        set_lane(2, 4'd9, 4'd8, 4'd2);
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check("bp_in_ready_empty", in_ready, 1);
        tick();
        check("bp_first_d", d, 8'h11);
        set_lane(1, 4'd12, 4'd10, 4'd4);
        sel = 2'd1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", in_ready, 0);
            check("bp_d_hold", d, 8'h11);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("release_d", d, 8'h08);
        check("release_valid", out_valid, 1);
        check("release_trc_count", trc_count, 2);
        tick();

        // Nine back-to-back adds on lane 0 push the log past DEPTH
        for (int k = 1; k <= 9; k++) begin
            set_lane(0, 4'(k), 4'd1, 4'd2);
            sel = 2'd0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        check("stream_last_d", d, 8'd10);
        tick();
        check("full_count", trc_count, 10);
        check("full_flag", trc_full, 1);
        trc_idx = 4'd0; #1;
        check("trc_oldest_e3", trc_data, 20'hCA408);
        trc_idx = 4'd9; #1;
        check("trc_newest_e12", trc_data, 20'h9120A);
        trc_idx = 4'd5; #1;
        check("trc_mid_e8", trc_data, 20'h51206);
        trc_idx = 4'd12; #1;
        check("trc_idx_oob", trc_data, 0);

        // Clear coincident with an output handshake
        set_lane(0, 4'd2, 4'd3, 4'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0; trc_clr = 1'b1;
        tick();
        trc_clr = 1'b0; trc_idx = 4'd0;
        #1;
        check("clr_count", trc_count, 0);
        check("clr_full", trc_full, 0);
        check("clr_data", trc_data, 0);
        tick();
        check("clr_not_logged", trc_count, 0);
        set_lane(0, 4'd3, 4'd3, 4'd2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("post_clr_count", trc_count, 1);
        check("post_clr_entry", trc_data, 20'h33206);

        // Reserved opcode, NOT A, NOR, XOR held under backpressure, then reset
        set_lane(0, 4'd5, 4'd5, 4'd13);
        set_lane(1, 4'd5, 4'd3, 4'd8);
        set_lane(2, 4'd5, 4'd3, 4'd11);
        set_lane(3, 4'd5, 4'd3, 4'd6);
        sel = 2'd1; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        check("misc_lane_res", lane_res, 32'h06080A00);
        check("misc_d", d, 8'h0A);
`ifdef DIST_ALU_FLAGS_EN
        check("flags_illegal", flags, 12'h005);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_d", d, 0);
        check("rst_mid_count", trc_count, 0);
        check("rst_mid_lane_res", lane_res, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
